// File: rtl/fir_pkg.sv
// Shared definitions for the serial FIR filter: FSM state encoding and width helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fir_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MAC  = 1'b1
    } fir_state_t;

    // Ceiling log2. Returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Accumulator width that can hold TAPS full-scale products without overflow.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered unsigned multiply-accumulate: acc <= clr ? 0 : (en ? acc + a*b : acc).
// Latency: sum is combinational from acc/a/b; acc updates on the next clk edge.
// Backpressure: none; the caller controls progress through clr/en.
// Ports: clk, rst_n (sync active-low), clr, en, a (A_W), b (B_W), sum (acc + a*b, ACC_W).
module fir_mac
    import fir_pkg::*;
#(
    parameter int TAPS  = 3,
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = acc_width(A_W, B_W, TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic [ACC_W-1:0] sum
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod;

    assign prod = ACC_W'(a) * ACC_W'(b);
    assign sum  = acc + prod;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/fir_ntap_serial.sv
// N-tap unsigned FIR with one shared MAC, runtime-loadable coefficients; FIR_SAT_EN selects saturating output.
// Latency: sample accepted at edge e0, yout/out_valid update at edge e(TAPS); one sample per TAPS+1 clocks.
// Backpressure: in_ready is high only in IDLE; the source holds xin/in_valid until accepted.
// Ports: clk, rst_n (sync active-low), in_valid/in_ready/xin sample input,
//        coef_we/coef_addr/coef_wdata coefficient write (IDLE only), yout/out_valid result strobe.
module fir_ntap_serial
    import fir_pkg::*;
#(
    parameter int TAPS   = 3,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      xin,
    input  logic                   coef_we,
    input  logic [clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]      coef_wdata,
    output logic [OUT_W-1:0]       yout,
    output logic                   out_valid
);

    localparam int ADDR_W = clog2(TAPS);
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);

    localparam logic [ADDR_W:0]   TAPS_L = (ADDR_W + 1)'(TAPS);
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(TAPS - 1);

    fir_state_t        state;
    logic [ADDR_W-1:0] k;
    logic [DATA_W-1:0] xd [TAPS];
    logic [COEF_W-1:0] h  [TAPS];

    logic              accept;
    logic              coef_ok;
    logic [DATA_W-1:0] x_sel;
    logic [COEF_W-1:0] h_sel;
    logic [ACC_W-1:0]  mac_sum;
    logic [OUT_W-1:0]  y_next;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    // Writes during MAC would corrupt the running sum, and out-of-range
    // addresses exist whenever TAPS is not a power of two.
    assign coef_ok  = coef_we && (state == ST_IDLE) && ({1'b0, coef_addr} < TAPS_L);

    assign x_sel = xd[k];
    assign h_sel = h[k];

    // The accumulator is cleared on the accept edge, so MAC cycle k adds h[k]*x[k]
    // and the last product is folded in combinationally via mac_sum.
    fir_mac #(
        .TAPS  (TAPS),
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state == ST_MAC),
        .a     (x_sel),
        .b     (h_sel),
        .sum   (mac_sum)
    );

    generate
        if (OUT_W >= ACC_W) begin : g_ext
            assign y_next = OUT_W'(mac_sum);
        end else begin : g_narrow
`ifdef FIR_SAT_EN
            assign y_next = (|mac_sum[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : mac_sum[OUT_W-1:0];
`else
            assign y_next = OUT_W'(mac_sum);
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            k         <= '0;
            yout      <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                xd[i] <= '0;
                h[i]  <= '0;
            end
        end else begin
            out_valid <= 1'b0;

            if (coef_ok) begin
                h[coef_addr] <= coef_wdata;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        for (int i = TAPS - 1; i > 0; i--) begin
                            xd[i] <= xd[i-1];
                        end
                        xd[0] <= xin;
                        k     <= '0;
                        state <= ST_MAC;
                    end
                end
                default: begin
                    if (k == K_LAST) begin
                        yout      <= y_next;
                        out_valid <= 1'b1;
                        k         <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_ntap_serial.sv
// Directed self-checking bench for fir_ntap_serial (default 3-tap instance plus an 8-tap, 12-bit instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_fir_ntap_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Default instance: TAPS=3, DATA_W=8, COEF_W=8, OUT_W=16
    logic        in_valid, in_ready, coef_we, out_valid;
    logic [7:0]  xin, coef_wdata;
    logic [1:0]  coef_addr;
    logic [15:0] yout;

    // Wide instance: TAPS=8, DATA_W=12
    logic        v2, r2, we2, ov2;
    logic [11:0] x2;
    logic [2:0]  a2;
    logic [7:0]  wd2;
    logic [15:0] y2;

    int checks   = 0;
    int failures = 0;

    fir_ntap_serial #(.TAPS(3), .DATA_W(8), .COEF_W(8), .OUT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .xin        (xin),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .yout       (yout),
        .out_valid  (out_valid)
    );

    fir_ntap_serial #(.TAPS(8), .DATA_W(12), .COEF_W(8), .OUT_W(16)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (v2),
        .in_ready   (r2),
        .xin        (x2),
        .coef_we    (we2),
        .coef_addr  (a2),
        .coef_wdata (wd2),
        .yout       (y2),
        .out_valid  (ov2)
    );

    // All tasks start and end at a negedge.
    task automatic load_coef(input logic [1:0] a, input logic [7:0] d);
        coef_we = 1'b1; coef_addr = a; coef_wdata = d;
        @(posedge clk); @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic load_coef8(input logic [2:0] a, input logic [7:0] d);
        we2 = 1'b1; a2 = a; wd2 = d;
        @(posedge clk); @(negedge clk);
        we2 = 1'b0;
    endtask

    // Offer one sample, optionally with a coefficient write in the accept cycle
    // (we_acc) or in the first MAC cycle (we_mac), then wait for the strobe.
    task automatic send(input logic [7:0] x, input logic [15:0] exp_y,
                        input bit we_acc, input bit we_mac,
                        input logic [1:0] a, input logic [7:0] d);
        int n;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready x=%0d got=%b want=1", x, in_ready);
        end
        in_valid = 1'b1; xin = x;
        if (we_acc) begin coef_we = 1'b1; coef_addr = a; coef_wdata = d; end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; coef_we = 1'b0;
        if (we_mac) begin coef_we = 1'b1; coef_addr = a; coef_wdata = d; end
        n = 0;
        while (n < 20) begin
            @(posedge clk); n++; @(negedge clk);
            coef_we = 1'b0;
            if (out_valid === 1'b1) break;
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL latency x=%0d got=%0d want=3", x, n);
        end
        checks++;
        if (yout !== exp_y) begin
            failures++;
            $display("FAIL yout x=%0d got=%0d want=%0d", x, yout, exp_y);
        end
    endtask

    task automatic send8(input logic [11:0] x, input logic [15:0] exp_y);
        int n;
        v2 = 1'b1; x2 = x;
        @(posedge clk); @(negedge clk);
        v2 = 1'b0;
        n = 0;
        while (n < 30) begin
            @(posedge clk); n++; @(negedge clk);
            if (ov2 === 1'b1) break;
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL latency8 x=%0d got=%0d want=8", x, n);
        end
        checks++;
        if (y2 !== exp_y) begin
            failures++;
            $display("FAIL yout8 x=%0d got=%0d want=%0d", x, y2, exp_y);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        checks++;
        if (yout !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset3 got y=%0d ov=%b rdy=%b want 0 0 1", yout, out_valid, in_ready);
        end
        checks++;
        if (y2 !== 16'd0 || ov2 !== 1'b0 || r2 !== 1'b1) begin
            failures++;
            $display("FAIL reset8 got y=%0d ov=%b rdy=%b want 0 0 1", y2, ov2, r2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        load_coef(2'd0, 8'd10);
        load_coef(2'd1, 8'd20);
        load_coef(2'd2, 8'd30);
        send(8'd3, 16'd30,  0, 0, 2'd0, 8'd0);
        send(8'd1, 16'd70,  0, 0, 2'd0, 8'd0);
        send(8'd1, 16'd120, 0, 0, 2'd0, 8'd0);
        send(8'd2, 16'd70,  0, 0, 2'd0, 8'd0);
    endtask

    // Delay line enters as {2,1,1}; samples 4,5,6 give 110,190,280 with h={10,20,30}.
    task automatic test_handshake;
        logic [7:0]  hs_x [3] = '{8'd4, 8'd5, 8'd6};
        logic [15:0] hs_y [3] = '{16'd110, 16'd190, 16'd280};
        int accepts;
        bit exp_rdy;
        accepts = 0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            exp_rdy = (i % 4 == 0);
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL hs_ready i=%0d got=%b want=%b", i, in_ready, exp_rdy);
            end
            checks++;
            if (out_valid !== (exp_rdy && i > 0)) begin
                failures++;
                $display("FAIL hs_valid i=%0d got=%b want=%b", i, out_valid, exp_rdy && i > 0);
            end
            if (exp_rdy && i > 0) begin
                checks++;
                if (yout !== hs_y[i/4-1]) begin
                    failures++;
                    $display("FAIL hs_yout i=%0d got=%0d want=%0d", i, yout, hs_y[i/4-1]);
                end
            end
            if (i == 12) begin
                in_valid = 1'b0;
            end else begin
                if (in_ready === 1'b1) begin
                    xin = hs_x[i/4];
                    accepts++;
                end
                @(posedge clk); @(negedge clk);
            end
        end
        checks++;
        if (accepts != 3) begin
            failures++;
            $display("FAIL hs_accepts got=%0d want=3", accepts);
        end
    endtask

    task automatic test_overflow;
        test_reset();
        load_coef(2'd0, 8'd255);
        load_coef(2'd1, 8'd255);
        load_coef(2'd2, 8'd255);
        send(8'd255, 16'd65025, 0, 0, 2'd0, 8'd0);
`ifdef FIR_SAT_EN
        send(8'd255, 16'd65535, 0, 0, 2'd0, 8'd0);
        send(8'd255, 16'd65535, 0, 0, 2'd0, 8'd0);
`else
        send(8'd255, 16'd64514, 0, 0, 2'd0, 8'd0);
        send(8'd255, 16'd64003, 0, 0, 2'd0, 8'd0);
`endif
    endtask

    task automatic test_coef_rules;
        test_reset();
        load_coef(2'd0, 8'd1);
        load_coef(2'd1, 8'd2);
        load_coef(2'd2, 8'd3);
        send(8'd1, 16'd1, 0, 1, 2'd1, 8'd99);   // h[1]=99 during MAC, dropped
        send(8'd0, 16'd2, 0, 0, 2'd0, 8'd0);    // x={0,1,0}: uses h[1]=2
        load_coef(2'd3, 8'd77);                 // out-of-range address, dropped
        send(8'd0, 16'd3, 0, 0, 2'd0, 8'd0);    // x={0,0,1}
        send(8'd1, 16'd1, 0, 0, 2'd0, 8'd0);    // x={1,0,0}
        send(8'd0, 16'd2, 0, 0, 2'd0, 8'd0);    // x={0,1,0}
        send(8'd2, 16'd13, 1, 0, 2'd0, 8'd5);   // x={2,0,1}, h0=5: 10+0+3
    endtask

    task automatic test_reset_mid_mac;
        in_valid = 1'b1; xin = 8'd1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || yout !== 16'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst got ov=%b y=%0d rdy=%b want 0 0 1", out_valid, yout, in_ready);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL midrst_strobe i=%0d got=%b want=0", i, out_valid);
            end
        end
        send(8'd4, 16'd0, 0, 0, 2'd0, 8'd0);
    endtask

    task automatic test_taps8;
        for (int i = 0; i < 8; i++) begin
            load_coef8(3'(i), 8'(i + 1));
        end
        send8(12'd1, 16'd1);
        for (int i = 2; i <= 8; i++) begin
            send8(12'd0, 16'(i));
        end
        send8(12'd0, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; xin = '0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        v2 = 1'b0; x2 = '0; we2 = 1'b0; a2 = '0; wd2 = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_handshake();
        test_overflow();
        test_coef_rules();
        test_reset_mid_mac();
        test_taps8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
